// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and timing helpers for the UART receiver
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_BITS = 8;

  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push while full is taken only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage is reset too so the head byte reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - 8N1 UART receiver feeding a small byte FIFO with
// framing-error and overrun pulses
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 1_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          serial_in,
  output logic [7:0]                    data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic                          rx_busy,
  output logic                          framing_error,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
  localparam int BW               = $clog2(DATA_BITS);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
  localparam logic [CW-1:0] SYMBOL_LAST = CW'(SYMBOL_EDGE_TIME - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop_sample, push, pop, fifo_full, fifo_empty;

  assign rx_s = sync_q[1];

  // Synchroniser resets to the idle-high line level so reset release cannot fake a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], serial_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == SYMBOL_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BW'(1);
          if (bit_idx_q == BW'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (cnt_q == SYMBOL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stop_sample   = (state_q == STOP) && (cnt_q == SYMBOL_LAST);
    push          = stop_sample && rx_s && (!fifo_full || pop);
    overrun       = stop_sample && rx_s && fifo_full && !pop;
    framing_error = stop_sample && !rx_s;
    rx_busy       = (state_q != IDLE);
  end

  assign data_out_valid = !fifo_empty;
  assign pop            = data_out_valid && data_out_ready;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (data_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb/tb_uart_rx_buffered.sv - directed self-checking bench for uart_rx_buffered
module tb_uart_rx_buffered;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial_in;
  logic       data_out_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       rx_busy;
  logic       framing_error;
  logic       overrun;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  uart_rx_buffered #(
    .CLOCK_FREQ (50_000_000),
    .BAUD_RATE  (1_000_000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .rx_busy        (rx_busy),
    .framing_error  (framing_error),
    .overrun        (overrun),
    .fifo_count     (fifo_count)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] popped[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         valid_cycles = 0;

  always @(negedge clk) begin
    if (data_out_valid && data_out_ready) popped.push_back(data_out);
    if (framing_error)  fe_cnt <= fe_cnt + 1;
    if (overrun)        ov_cnt <= ov_cnt + 1;
    if (data_out_valid) valid_cycles <= valid_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives the first ncyc cycles of a 50-cycle-per-bit frame; the line keeps its last level.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int ncyc);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int c = 0; c < ncyc && c < 500; c++) begin
      serial_in = fr[c / 50];
      tick();
    end
  endtask

  task automatic check_pop(input string tag, input int idx, input logic [7:0] exp);
    logic [31:0] got;
    got = (idx < popped.size()) ? {24'h0, popped[idx]} : 32'hDEAD;
    check_eq(tag, got, {24'h0, exp});
  endtask

  int pop_base, fe_base, ov_base, vc_base;

  task automatic mark();
    pop_base = popped.size();
    fe_base  = fe_cnt;
    ov_base  = ov_cnt;
    vc_base  = valid_cycles;
  endtask

  initial begin
    rst_n          = 1'b0;
    serial_in      = 1'b1;
    data_out_ready = 1'b0;
    idle(3);
    check_eq("rst_valid", data_out_valid, 0);
    check_eq("rst_data", data_out, 0);
    check_eq("rst_count", fifo_count, 0);
    check_eq("rst_busy", rx_busy, 0);
    check_eq("rst_fe", framing_error, 0);
    check_eq("rst_ov", overrun, 0);
    rst_n = 1'b1;
    idle(5);

    // Single byte
    data_out_ready = 1'b1;
    mark();
    drive_frame(8'h61, 1'b1, 500);
    idle(20);
    check_eq("single_npop", popped.size() - pop_base, 1);
    check_pop("single_data", pop_base, 8'h61);
    check_eq("single_vcycles", valid_cycles - vc_base, 1);
    check_eq("single_count", fifo_count, 0);
    check_eq("single_fe", fe_cnt - fe_base, 0);
    check_eq("single_ov", ov_cnt - ov_base, 0);

    // Back-to-back frames
    mark();
    for (int i = 0; i < 10; i++) drive_frame(8'h61 + 8'(i), 1'b1, 500);
    idle(20);
    check_eq("b2b_npop", popped.size() - pop_base, 10);
    for (int i = 0; i < 10; i++) check_pop($sformatf("b2b_data%0d", i), pop_base + i, 8'h61 + 8'(i));
    check_eq("b2b_fe", fe_cnt - fe_base, 0);
    check_eq("b2b_ov", ov_cnt - ov_base, 0);

    // Glitch on the line
    mark();
    serial_in = 1'b0;
    idle(10);
    check_eq("glitch_busy_hi", rx_busy, 1);
    serial_in = 1'b1;
    idle(40);
    check_eq("glitch_busy_lo", rx_busy, 0);
    check_eq("glitch_count", fifo_count, 0);
    check_eq("glitch_npop", popped.size() - pop_base, 0);
    check_eq("glitch_fe", fe_cnt - fe_base, 0);

    // Framing error, then a good frame
    mark();
    drive_frame(8'h55, 1'b0, 500);
    serial_in = 1'b1;
    idle(100);
    check_eq("fe_pulses", fe_cnt - fe_base, 1);
    check_eq("fe_count", fifo_count, 0);
    check_eq("fe_npop", popped.size() - pop_base, 0);
    check_eq("fe_ov", ov_cnt - ov_base, 0);
    drive_frame(8'hA3, 1'b1, 500);
    idle(20);
    check_eq("fe_next_npop", popped.size() - pop_base, 1);
    check_pop("fe_next_data", pop_base, 8'hA3);
    check_eq("fe_next_fe", fe_cnt - fe_base, 1);

    // Backpressure and overrun
    data_out_ready = 1'b0;
    mark();
    for (int i = 0; i < 4; i++) drive_frame(8'h10 + 8'(i), 1'b1, 500);
    idle(10);
    check_eq("ovr_count4", fifo_count, 4);
    check_eq("ovr_none_yet", ov_cnt - ov_base, 0);
    check_eq("ovr_head", data_out, 8'h10);
    drive_frame(8'h14, 1'b1, 500);
    idle(10);
    check_eq("ovr_pulse", ov_cnt - ov_base, 1);
    check_eq("ovr_count_full", fifo_count, 4);
    check_eq("ovr_fe", fe_cnt - fe_base, 0);
    check_eq("ovr_npop", popped.size() - pop_base, 0);
    // Pop exactly on the stop-sample cycle of the next frame while full
    fork
      drive_frame(8'h15, 1'b1, 500);
      begin
        idle(477);
        data_out_ready = 1'b1;
        tick();
        data_out_ready = 1'b0;
      end
    join
    idle(10);
    check_eq("pp_count", fifo_count, 4);
    check_eq("pp_no_ov", ov_cnt - ov_base, 1);
    check_eq("pp_npop", popped.size() - pop_base, 1);
    data_out_ready = 1'b1;
    idle(10);
    check_eq("drain_npop", popped.size() - pop_base, 5);
    check_pop("drain0", pop_base + 0, 8'h10);
    check_pop("drain1", pop_base + 1, 8'h11);
    check_pop("drain2", pop_base + 2, 8'h12);
    check_pop("drain3", pop_base + 3, 8'h13);
    check_pop("drain4", pop_base + 4, 8'h15);
    check_eq("drain_count", fifo_count, 0);

    // Reset in the middle of a frame with a byte queued
    data_out_ready = 1'b0;
    mark();
    drive_frame(8'h42, 1'b1, 500);
    idle(10);
    drive_frame(8'h7E, 1'b1, 225);
    check_eq("mid_busy", rx_busy, 1);
    check_eq("mid_count", fifo_count, 1);
    rst_n     = 1'b0;
    serial_in = 1'b1;
    #1;
    check_eq("mrst_valid", data_out_valid, 0);
    check_eq("mrst_data", data_out, 0);
    check_eq("mrst_count", fifo_count, 0);
    check_eq("mrst_busy", rx_busy, 0);
    check_eq("mrst_err", {framing_error, overrun}, 0);
    idle(3);
    rst_n          = 1'b1;
    data_out_ready = 1'b1;
    idle(20);
    check_eq("post_rst_npop", popped.size() - pop_base, 0);
    drive_frame(8'h7E, 1'b1, 500);
    idle(20);
    check_eq("post_rst_npop2", popped.size() - pop_base, 1);
    check_pop("post_rst_data", pop_base, 8'h7E);
    check_eq("post_rst_err", (fe_cnt - fe_base) + (ov_cnt - ov_base), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
- On-chip UART receiver: deserialises 8N1 frames from `serial_in` and queues received bytes in a small FIFO.
- Bytes are delivered to the CPU's memory-mapped UART logic over a ready/valid interface.
- It is the FPGA-side counterpart of the host transmit path that drives `serial_in`.
- Adds framing-error and overrun reporting for software.

Parameters:
- CLOCK_FREQ, 50_000_000, core clock frequency in Hz.
- BAUD_RATE, 1_000_000, line rate in bit/s.
- FIFO_DEPTH, 4, received-byte queue depth; must be a power of two and at least 2.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- serial_in  in  1  asynchronous RX line; idle high.
- data_out  out  8  byte at the FIFO head.
- data_out_valid  out  1  FIFO non-empty.
- data_out_ready  in  1  consumer accepts the head byte when high together with valid.
- rx_busy  out  1  a frame is in progress (FSM not IDLE).
- framing_error  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  one-cycle pulse: valid frame dropped because the FIFO was full.
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of queued bytes.

Behaviour:
- Reset is asynchronous (one clock, `clk`; reset `rst_n`, active-low).
  - All outputs are 0 while `rst_n` is low.
  - Synchroniser flops reset to 1.
  - FSM resets to IDLE; FIFO pointers and count reset to 0.
- Timing constants:
  - SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (50 at defaults).
  - SAMPLE_TIME = SYMBOL_EDGE_TIME / 2.
  - Bit counter width = clog2(SYMBOL_EDGE_TIME).
- `serial_in` passes through a 2-flop synchroniser; `rx_s` is the synchronised line.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: when `rx_s` == 0, go to START and clear the cycle counter.
  - START: at counter == SAMPLE_TIME-1, sample `rx_s`.
    - Sample 0: go to DATA, clear the counter and bit index.
    - Sample 1: treat as a glitch and return to IDLE; no error flag.
  - DATA: every SYMBOL_EDGE_TIME cycles (i.e. at mid-bit), shift `rx_s` into the shift register, LSB first. After bit index 7, go to STOP.
  - STOP: at mid-bit, sample `rx_s`.
    - Sample 1 and FIFO has space: push the shift register.
    - Sample 1 and FIFO full: pulse `overrun`, drop the byte.
    - Sample 0: pulse `framing_error`, no push.
    - In every case, return to IDLE in the same cycle.
    - Returning at mid-stop is required so back-to-back frames are caught.
- Latency: `data_out_valid` rises on the cycle after the stop-bit sample, when the FIFO was previously empty.
- FIFO:
  - Pop occurs when `data_out_valid && data_out_ready`.
  - Push and pop in the same cycle: both take effect and `fifo_count` is unchanged. This applies when full too (push accepted, no overrun).
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - `data_out` is combinational from the head entry.
  - `data_out` is held stable while valid and not ready.
- `framing_error` and `overrun` are single-cycle and mutually exclusive.
- `rx_busy` = (state != IDLE).
- Reset mid-frame: the partial frame is discarded and the FIFO is emptied. After `rst_n` deasserts, the next falling edge starts a fresh frame.

Decomposition:
- Package `uart_pkg`:
  - rx state enum (IDLE, START, DATA, STOP).
  - `DATA_BITS` = 8.
  - Function computing `SYMBOL_EDGE_TIME` from CLOCK_FREQ and BAUD_RATE.
- One sub-module `sync_fifo`:
  - Parameters: width 8, depth FIFO_DEPTH.
  - Ports: push/pop/full/empty/count.
  - Reset: async active-low.
- Synchroniser and FSM live in the top module.

Test Plan:
- Single byte: drive 0x61 at 50 cycles/bit with `data_out_ready`=1 → `data_out_valid` pulses 1 cycle with `data_out`=0x61; `fifo_count` returns to 0; no error pulses.
- Back-to-back: send 0x61..0x6A with zero idle between frames, ready=1 → ten bytes popped in order 0x61..0x6A; no `framing_error`, no `overrun`.
- Glitch: drive `serial_in` low for 10 cycles then high → state returns to IDLE; `rx_busy` falls; no push; `fifo_count`=0.
- Framing error: send 0x55 with stop bit 0 → `framing_error` 1-cycle pulse; `fifo_count` stays 0. A following valid frame 0xA3 is received correctly.
- Overrun/backpressure: ready=0, send 0x10..0x14 → `fifo_count`=4, `overrun` pulses on the fifth frame. Then ready=1 drains 0x10,0x11,0x12,0x13 in order. A simultaneous push/pop at full leaves `fifo_count`=4 with no overrun.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0x7E → all outputs go to 0 immediately. After release, send 0x7E → received as 0x7E.
